// File: rtl/pipeline_monitor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipeline_monitor_pkg                                             |
// | Purpose : Shared types and default parameters for the run/trace monitor.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package pipeline_monitor_pkg;

  localparam int DEFAULT_CNT_W        = 32;
  localparam int DEFAULT_N_EVENTS     = 4;
  localparam int DEFAULT_TRACE_DEPTH  = 16;
  localparam int DEFAULT_DRAIN_CYCLES = 5;
  localparam int DEFAULT_PC_W         = 64;

  // Trace storage is sized for the widest supported PC; narrower PCs are
  // zero-extended on write and truncated on read.
  localparam int TRACE_PC_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  typedef struct packed {
    logic [TRACE_PC_MAX_W-1:0] pc;
    logic [31:0]               instr;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : trace_fifo                                                       |
// | Purpose : Show-ahead trace FIFO; drops pushes when full, sticky overflow.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module trace_fifo
  import pipeline_monitor_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TRACE_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  trace_entry_t           push_entry,
  input  logic                   pop_ready,
  output logic                   rd_valid,
  output trace_entry_t           rd_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

  trace_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          empty, full, do_pop, do_push;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_COUNT);
    do_pop     = pop_ready && !empty && !clear;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push    = push && (!full || do_pop) && !clear;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
      if (push && full && !do_pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset: slot contents are only observable once pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign rd_valid = !empty;
  assign rd_entry = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_trace_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipeline_trace_monitor                                           |
// | Purpose : Run FSM, saturating cycle/retire/event counters, retire trace.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipeline_trace_monitor
  import pipeline_monitor_pkg::*;
#(
  parameter int CNT_W        = DEFAULT_CNT_W,
  parameter int N_EVENTS     = DEFAULT_N_EVENTS,
  parameter int TRACE_DEPTH  = DEFAULT_TRACE_DEPTH,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int PC_W         = DEFAULT_PC_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          clear,
  input  logic                          end_program,
  input  logic                          retire_valid,
  input  logic [PC_W-1:0]               retire_pc,
  input  logic [31:0]                   retire_instr,
  input  logic [N_EVENTS-1:0]           event_in,
  input  logic                          trace_rd_ready,
  output logic                          trace_rd_valid,
  output logic [PC_W-1:0]               trace_rd_pc,
  output logic [31:0]                   trace_rd_instr,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic                          trace_overflow,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [CNT_W-1:0]              retired_count,
  output logic [N_EVENTS*CNT_W-1:0]     event_counts,
  output logic                          busy,
  output logic                          done
);

  localparam int               DW       = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DW-1:0]    DRAIN_LD = DW'(DRAIN_CYCLES);

  mon_state_e    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic          active;
  trace_entry_t  push_entry, rd_entry;

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (clear) begin
      state_d = ST_IDLE;
      drain_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (end_program) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LD;
          end
        end
        ST_DRAIN: begin
          drain_d = drain_q - 1'b1;
          if (drain_q == DW'(1)) state_d = ST_DONE;
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cycle_d   = cycle_q;
    retired_d = retired_q;
    if (clear) begin
      cycle_d   = '0;
      retired_d = '0;
    end else if (active) begin
      if (cycle_q != CNT_MAX) cycle_d = cycle_q + 1'b1;
      if (retire_valid && retired_q != CNT_MAX) retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  for (genvar i = 0; i < N_EVENTS; i++) begin : g_evt
    logic [CNT_W-1:0] evt_q, evt_d;

    always_comb begin
      evt_d = evt_q;
      if (clear) evt_d = '0;
      else if (active && event_in[i] && evt_q != CNT_MAX) evt_d = evt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) evt_q <= '0;
      else       evt_q <= evt_d;
    end

    assign event_counts[i*CNT_W +: CNT_W] = evt_q;
  end

  always_comb begin
    push_entry                = '0;
    push_entry.pc[PC_W-1:0]   = retire_pc;
    push_entry.instr          = retire_instr;
  end

  trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .push       (retire_valid && active),
    .push_entry (push_entry),
    .pop_ready  (trace_rd_ready),
    .rd_valid   (trace_rd_valid),
    .rd_entry   (rd_entry),
    .count      (trace_count),
    .overflow   (trace_overflow)
  );

  assign trace_rd_pc    = rd_entry.pc[PC_W-1:0];
  assign trace_rd_instr = rd_entry.instr;
  assign cycle_count    = cycle_q;
  assign retired_count  = retired_q;
  assign busy           = active;
  assign done           = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_trace_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipeline_trace_monitor                                        |
// | Purpose : Table-driven and directed self-checking bench for the monitor.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pipeline_trace_monitor;

  logic        clk = 1'b0;
  logic        reset, start, clear, end_program, retire_valid, trace_rd_ready;
  logic [63:0] retire_pc;
  logic [31:0] retire_instr;
  logic [3:0]  event_in;

  logic        rd_valid, ovf, busy, done;
  logic [63:0] rd_pc;
  logic [31:0] rd_instr, cyc, ret;
  logic [2:0]  tcnt;
  logic [127:0] evs;

  logic        s_rd_valid, s_ovf, s_busy, s_done;
  logic [63:0] s_rd_pc;
  logic [31:0] s_rd_instr;
  logic [2:0]  s_tcnt;
  logic [3:0]  s_cyc, s_ret;
  logic [15:0] s_evs;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_trace_monitor #(
    .CNT_W(32), .N_EVENTS(4), .TRACE_DEPTH(4), .DRAIN_CYCLES(5), .PC_W(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .end_program(end_program), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .retire_instr(retire_instr), .event_in(event_in),
    .trace_rd_ready(trace_rd_ready), .trace_rd_valid(rd_valid),
    .trace_rd_pc(rd_pc), .trace_rd_instr(rd_instr), .trace_count(tcnt),
    .trace_overflow(ovf), .cycle_count(cyc), .retired_count(ret),
    .event_counts(evs), .busy(busy), .done(done)
  );

  // Narrow-counter instance for saturation checks.
  pipeline_trace_monitor #(
    .CNT_W(4), .N_EVENTS(4), .TRACE_DEPTH(4), .DRAIN_CYCLES(5), .PC_W(64)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .end_program(end_program), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .retire_instr(retire_instr), .event_in(event_in),
    .trace_rd_ready(trace_rd_ready), .trace_rd_valid(s_rd_valid),
    .trace_rd_pc(s_rd_pc), .trace_rd_instr(s_rd_instr), .trace_count(s_tcnt),
    .trace_overflow(s_ovf), .cycle_count(s_cyc), .retired_count(s_ret),
    .event_counts(s_evs), .busy(s_busy), .done(s_done)
  );

  typedef struct {
    logic        st, ep, rv;
    logic [63:0] pc;
    logic        rdy, clr;
    logic [3:0]  ev;
    logic        x_busy, x_done;
    logic [2:0]  x_cnt;
    logic [63:0] x_pc;
    logic [31:0] x_cyc, x_ret, x_ev0;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'hDEAD_0000;
  endfunction

  task automatic step(input logic s, input logic ep, input logic rv, input logic [63:0] pc,
                      input logic rdy, input logic clr, input logic [3:0] ev);
    start          = s;
    end_program    = ep;
    retire_valid   = rv;
    retire_pc      = pc;
    retire_instr   = instr_of(pc);
    trace_rd_ready = rdy;
    clear          = clr;
    event_in       = ev;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 4'd0);
  endtask

  task automatic do_start();
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cyc"}, cyc, 32'd0);
    chk({tag, "_ret"}, ret, 32'd0);
    chk({tag, "_evs"}, evs, 128'd0);
    chk({tag, "_tcnt"}, tcnt, 3'd0);
    chk({tag, "_valid"}, rd_valid, 1'b0);
    chk({tag, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    // Columns: st ep rv pc rdy clr ev | busy done cnt head_pc cyc ret ev0
    vt[0]  = '{1,0,0,64'h000,0,0,4'b0000, 1,0,3'd0,64'h000, 0, 0,0};
    vt[1]  = '{0,0,1,64'h100,0,0,4'b0001, 1,0,3'd1,64'h100, 1, 1,1};
    vt[2]  = '{1,0,1,64'h104,0,0,4'b0000, 1,0,3'd2,64'h100, 2, 2,1};
    vt[3]  = '{0,0,0,64'h000,1,0,4'b0000, 1,0,3'd1,64'h104, 3, 2,1};
    vt[4]  = '{0,0,1,64'h108,1,0,4'b0001, 1,0,3'd1,64'h108, 4, 3,2};
    vt[5]  = '{0,1,0,64'h000,0,0,4'b0000, 1,0,3'd1,64'h108, 5, 3,2};
    vt[6]  = '{0,0,1,64'h10C,0,0,4'b0000, 1,0,3'd2,64'h108, 6, 4,2};
    vt[7]  = '{0,0,0,64'h000,0,0,4'b0001, 1,0,3'd2,64'h108, 7, 4,3};
    vt[8]  = '{0,0,0,64'h000,0,0,4'b0000, 1,0,3'd2,64'h108, 8, 4,3};
    vt[9]  = '{0,1,0,64'h000,0,0,4'b0000, 1,0,3'd2,64'h108, 9, 4,3};
    vt[10] = '{0,0,0,64'h000,0,0,4'b0000, 0,1,3'd2,64'h108,10, 4,3};
    vt[11] = '{1,0,1,64'h200,0,0,4'b0001, 0,1,3'd2,64'h108,10, 4,3};
    vt[12] = '{0,0,0,64'h000,1,0,4'b0000, 0,1,3'd1,64'h10C,10, 4,3};
    vt[13] = '{0,0,1,64'h300,1,1,4'b0001, 0,0,3'd0,64'h000, 0, 0,0};
    vt[14] = '{0,0,0,64'h000,1,0,4'b0000, 0,0,3'd0,64'h000, 0, 0,0};

    reset = 1'b1;
    start = 0; clear = 0; end_program = 0; retire_valid = 0;
    retire_pc = '0; retire_instr = '0; event_in = '0; trace_rd_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    idle();

    for (int i = 0; i < 15; i++) begin
      step(vt[i].st, vt[i].ep, vt[i].rv, vt[i].pc, vt[i].rdy, vt[i].clr, vt[i].ev);
      chk($sformatf("v%0d_busy", i), busy, vt[i].x_busy);
      chk($sformatf("v%0d_done", i), done, vt[i].x_done);
      chk($sformatf("v%0d_tcnt", i), tcnt, vt[i].x_cnt);
      chk($sformatf("v%0d_valid", i), rd_valid, vt[i].x_cnt != 3'd0);
      chk($sformatf("v%0d_cyc", i), cyc, vt[i].x_cyc);
      chk($sformatf("v%0d_ret", i), ret, vt[i].x_ret);
      chk($sformatf("v%0d_ev0", i), evs[31:0], vt[i].x_ev0);
      chk($sformatf("v%0d_ovf", i), ovf, 1'b0);
      if (vt[i].x_cnt != 3'd0) begin
        chk($sformatf("v%0d_pc", i), rd_pc, vt[i].x_pc);
        chk($sformatf("v%0d_instr", i), rd_instr, instr_of(vt[i].x_pc));
      end
    end

    // Basic run: start at edge 0, end_program at edge 10, done after edge 15.
    do_clear();
    do_start();
    for (int i = 1; i <= 9; i++) begin
      idle();
      chk($sformatf("run_busy_%0d", i), busy, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    chk("run_busy_10", busy, 1'b1);
    for (int j = 1; j <= 5; j++) begin
      idle();
      if (j < 5) begin
        chk($sformatf("drain_busy_%0d", j), busy, 1'b1);
        chk($sformatf("drain_done_%0d", j), done, 1'b0);
      end
    end
    chk("run_done", done, 1'b1);
    chk("run_busy_end", busy, 1'b0);
    chk("run_cyc", cyc, 32'd15);

    // Overflow: six retires into a 4-deep FIFO without draining.
    do_clear();
    do_start();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 64'(4 * i), 1'b0, 1'b0, 4'd0);
    chk("ovf_tcnt", tcnt, 3'd4);
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_ret", ret, 32'd6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_pop_pc_%0d", i), rd_pc, 64'(4 * i));
      chk($sformatf("ovf_pop_instr_%0d", i), rd_instr, instr_of(64'(4 * i)));
      step(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 4'd0);
    end
    chk("ovf_empty_valid", rd_valid, 1'b0);
    chk("ovf_sticky", ovf, 1'b1);
    do_clear();
    chk("ovf_cleared", ovf, 1'b0);

    // Full FIFO with simultaneous push and pop.
    do_start();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 64'(64 + 4 * i), 1'b0, 1'b0, 4'd0);
    chk("pp_full_tcnt", tcnt, 3'd4);
    chk("pp_head0", rd_pc, 64'h40);
    step(1'b0, 1'b0, 1'b1, 64'h50, 1'b1, 1'b0, 4'd0);
    chk("pp_tcnt", tcnt, 3'd4);
    chk("pp_ovf", ovf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_head_%0d", i), rd_pc, 64'(68 + 4 * i));
      step(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 4'd0);
    end
    chk("pp_drained", tcnt, 3'd0);

    // Saturation: 20 RUN cycles with event 2 held high.
    do_clear();
    do_start();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 4'b0100);
    chk("sat_cyc4", s_cyc, 4'd15);
    chk("sat_ev2_4", s_evs[11:8], 4'd15);
    chk("sat_ev0_4", s_evs[3:0], 4'd0);
    chk("sat_cyc32", cyc, 32'd20);
    chk("sat_ev2_32", evs[95:64], 32'd20);

    // Clear on the 2nd drain cycle; done must never rise, then a fresh run.
    do_clear();
    do_start();
    idle();
    idle();
    step(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0);
    idle();
    chk("cd_busy_drain", busy, 1'b1);
    do_clear();
    chk("cd_busy", busy, 1'b0);
    chk("cd_cyc", cyc, 32'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk($sformatf("cd_nodone_%0d", i), done, 1'b0);
    end
    do_start();
    chk("cd_restart_busy", busy, 1'b1);
    chk("cd_restart_cyc0", cyc, 32'd0);
    idle();
    chk("cd_restart_cyc1", cyc, 32'd1);

    // Asynchronous reset mid-run at cycle_count = 7.
    do_clear();
    do_start();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 64'(8 * i), 1'b0, 1'b0, 4'b1111);
    chk("mr_cyc7", cyc, 32'd7);
    chk("mr_ovf_pre", ovf, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("mr");
    chk("mr_sat_cyc", s_cyc, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    chk("mr_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
